// File: rtl/comparador_serial_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: state codes and FSM encodings.
package comparador_defs;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_EQ   = 2'b01;
    localparam logic [1:0] CODE_GT   = 2'b10;
    localparam logic [1:0] CODE_LT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/comparador_serial_celda.sv
// Single MSB-first comparison cell: refines an "equal so far" code with one bit pair.
module celda_comparacion
    import comparador_defs::*;
(
    input  logic [1:0] code_in,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic [1:0] code_out
);

    always_comb begin
        code_out = code_in;
        if (code_in == CODE_EQ) begin
            if (a_bit == b_bit) begin
                code_out = CODE_EQ;
            end else if (a_bit) begin
                code_out = CODE_GT;
            end else begin
                code_out = CODE_LT;
            end
        end
    end

endmodule

// File: rtl/comparador_serial.sv
// Bit-serial comparator controller: latches operands, walks one cell from MSB to LSB,
// and stops at the first differing bit.
module comparador_serial
    import comparador_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             y,
    output logic             z,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int IW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       code;
    logic [1:0]       code_next;
    logic [IW-1:0]    idx;
    logic             finish;

    celda_comparacion u_celda (
        .code_in  (code),
        .a_bit    (a_reg[idx]),
        .b_bit    (b_reg[idx]),
        .code_out (code_next)
    );

    // Stop on the first decided bit, or after the LSB so idx never wraps.
    assign finish = (code_next != CODE_EQ) || (idx == '0);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start) next_state = ST_COMPARE;
            ST_COMPARE: if (finish) next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == ST_COMPARE);
            done  <= (next_state == ST_DONE);
        end
    end

    // Operands carry no reset: they are only observed after an accepted start.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start && !rst) begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code <= CODE_NONE;
            idx  <= '0;
            y    <= 1'b0;
            z    <= 1'b0;
            gt   <= 1'b0;
            lt   <= 1'b0;
            eq   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        code <= CODE_EQ;
                        idx  <= IW'(WIDTH - 1);
                        y    <= 1'b0;
                        z    <= 1'b0;
                        gt   <= 1'b0;
                        lt   <= 1'b0;
                        eq   <= 1'b0;
                    end
                end
                ST_COMPARE: begin
                    code <= code_next;
                    if (finish) begin
                        y  <= code_next[1];
                        z  <= code_next[0];
                        gt <= (code_next == CODE_GT);
                        lt <= (code_next == CODE_LT);
                        eq <= (code_next == CODE_EQ);
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serial.sv
// Directed bench for comparador_serial (WIDTH=8): latency, result codes, start filtering, reset abort.
module tb_comparador_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       y;
    logic       z;
    logic       gt;
    logic       lt;
    logic       eq;

    int checks = 0;
    int errors = 0;

    comparador_serial #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .z     (z),
        .gt    (gt),
        .lt    (lt),
        .eq    (eq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] va, input logic [7:0] vb);
        a = va;
        b = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle T0+1; lat is the cycle offset of done, or -1 on timeout.
    task automatic wait_done(output int lat, output int bcnt);
        lat = -1;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy === 1'b1) bcnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom_range(1));
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_done cycle %0d: got %b want 0", i, done);
            end
        end
        checks++;
        if ({busy, done, y, z, gt, lt, eq} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000000", {busy, done, y, z, gt, lt, eq});
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
    endtask

    task automatic test_equal();
        int lat, bcnt;
        start_op(8'hA5, 8'hA5);
        wait_done(lat, bcnt);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL equal_latency: got %0d want 9", lat);
        end
        checks++;
        if (bcnt != 8) begin
            errors++;
            $display("FAIL equal_busy_cycles: got %0d want 8", bcnt);
        end
        checks++;
        if ({busy, y, z, gt, lt, eq} !== 6'b0_01_001) begin
            errors++;
            $display("FAIL equal_result: got busy,yz,gt,lt,eq=%b want 001001", {busy, y, z, gt, lt, eq});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL equal_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_msb_differs();
        int lat, bcnt;
        start_op(8'h80, 8'h7F);
        wait_done(lat, bcnt);
        checks++;
        if (lat != 2 || bcnt != 1) begin
            errors++;
            $display("FAIL msb_latency: got lat=%0d busy=%0d want lat=2 busy=1", lat, bcnt);
        end
        checks++;
        if ({y, z, gt, lt, eq} !== 5'b10_100) begin
            errors++;
            $display("FAIL msb_result: got yz,gt,lt,eq=%b want 10100", {y, z, gt, lt, eq});
        end
        tick();
    endtask

    task automatic test_lsb_hold_clear();
        int lat, bcnt;
        start_op(8'h12, 8'h13);
        wait_done(lat, bcnt);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL lsb_latency: got %0d want 9", lat);
        end
        checks++;
        if ({y, z, gt, lt, eq} !== 5'b11_010) begin
            errors++;
            $display("FAIL lsb_result: got yz,gt,lt,eq=%b want 11010", {y, z, gt, lt, eq});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({busy, done, y, z, gt, lt, eq} !== 7'b00_11_010) begin
                errors++;
                $display("FAIL lsb_hold idle %0d: got %b want 0011010", i, {busy, done, y, z, gt, lt, eq});
            end
        end
        start_op(8'h01, 8'h01);
        checks++;
        if ({busy, y, z, gt, lt, eq} !== 6'b1_00_000) begin
            errors++;
            $display("FAIL lsb_clear_on_start: got busy,yz,gt,lt,eq=%b want 100000", {busy, y, z, gt, lt, eq});
        end
        wait_done(lat, bcnt);
        tick();
    endtask

    task automatic test_start_ignored();
        int lat, bcnt;
        a = 8'h30;
        b = 8'h31;
        start = 1'b1;
        tick();
        a = 8'hFF;
        b = 8'h00;
        wait_done(lat, bcnt);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL busy_restart_latency: got %0d want 9", lat);
        end
        checks++;
        if ({y, z, gt, lt, eq} !== 5'b11_010) begin
            errors++;
            $display("FAIL busy_latched_operands: got yz,gt,lt,eq=%b want 11010", {y, z, gt, lt, eq});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL done_start_ignored: got busy,done=%b want 00", {busy, done});
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL idle_start_accepted: got busy=%b want 1", busy);
        end
        start = 1'b0;
        wait_done(lat, bcnt);
        checks++;
        if (lat != 2 || {y, z, gt, lt, eq} !== 5'b10_100) begin
            errors++;
            $display("FAIL second_start_result: got lat=%0d yz,gt,lt,eq=%b want lat=2 10100", lat, {y, z, gt, lt, eq});
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int lat, bcnt;
        int seen;
        start_op(8'hA5, 8'hA5);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, y, z, gt, lt, eq} !== 7'b0) begin
            errors++;
            $display("FAIL abort_outputs: got %b want 0000000", {busy, done, y, z, gt, lt, eq});
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
        end
        start_op(8'h01, 8'h00);
        wait_done(lat, bcnt);
        checks++;
        if (lat != 9 || {y, z, gt, lt, eq} !== 5'b10_100) begin
            errors++;
            $display("FAIL after_abort_result: got lat=%0d yz,gt,lt,eq=%b want lat=9 10100", lat, {y, z, gt, lt, eq});
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        test_reset();
        test_equal();
        test_msb_differs();
        test_lsb_hold_clear();
        test_start_ignored();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparador_serial.md
# comparador_serial

Bit-serial magnitude comparator controller for the left-to-right (MSB-first) comparison datapath. It latches two WIDTH-bit operands on a start request. It then drives a single comparison cell one bit per cycle, feeding back the cell's 2-bit state code, and stops at the first differing bit or after the LSB. It replaces a WIDTH-cell combinational chain with one cell plus sequencing, for area-constrained instances of the comparator.

## Interface

- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; latched on accepted start.
- b  in  WIDTH  operand B; latched on accepted start.
- busy  out  1  high while in COMPARE.
- done  out  1  one-cycle pulse when the result becomes valid.
- y  out  1  state code bit 1 (registered).
- z  out  1  state code bit 0 (registered).
- gt  out  1  A > B; valid from done until the next accepted start.
- lt  out  1  A < B; same validity as gt.
- eq  out  1  A == B; same validity as gt.

## Operation

- State code {y,z}:
  - 00 = no result.
  - 01 = equal so far / equal.
  - 10 = A>B.
  - 11 = A<B.
- Cell function: if incoming code ≠ 01, pass it through unchanged. Otherwise:
  - a_bit == b_bit → 01.
  - a_bit=1, b_bit=0 → 10.
  - a_bit=0, b_bit=1 → 11.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - start=1 → latch a, b into operand registers.
  - Load the internal code with 01, set bit index idx=WIDTH-1, clear y/z/gt/lt/eq to 0.
  - Go to COMPARE.
- COMPARE, each cycle:
  - Apply latched bits a[idx] and b[idx] with the internal code to the cell and register the new code.
  - If the new code ≠ 01, or idx==0 → go to DONE and copy the new code to y/z.
  - Set gt = (code==10), lt = (code==11), eq = (code==01).
  - Otherwise decrement idx.
- DONE: done=1 for exactly this cycle, then unconditionally go to IDLE. start is ignored in DONE.
- start is ignored in COMPARE and DONE, with no queuing. Changes on a/b after latch have no effect.
- Results (y, z, gt, lt, eq) hold in IDLE until the next accepted start clears them. Exactly one of gt/lt/eq is high while a result is valid.
- idx is a $clog2(WIDTH)-bit down-counter and never wraps: leaving at idx==0 is mandatory.

## Timing

- Reset values: FSM=IDLE, busy=0, done=0, y=0, z=0, gt=0, lt=0, eq=0, idx=0, internal code=00.
- rst has priority over every other input in any state. Reset during COMPARE or DONE aborts with no done pulse, and all outputs take their reset values on the next edge.
- Accepted start at edge T0:
  - busy=1 from T0+1.
  - For a first differing bit at position p, COMPARE lasts WIDTH-p cycles.
  - done=1 and results valid in cycle T0+(WIDTH-p)+1; busy=0 in that cycle.
- Equal operands: COMPARE lasts WIDTH cycles, done in cycle T0+WIDTH+1.
- Minimum start-to-start spacing: latency+1 cycles, because start is accepted on the cycle after DONE, from IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure

- Shared package/header comparador_defs: code constants CODE_NONE=2'b00, CODE_EQ=2'b01, CODE_GT=2'b10, CODE_LT=2'b11, and FSM state encodings ST_IDLE, ST_COMPARE, ST_DONE (2-bit).
- Sub-module celda_comparacion: purely combinational, with inputs code_in[1:0], a_bit, b_bit and output code_out[1:0], implementing the cell function above. Exactly one instance.
- The top level contains the FSM, operand registers, idx counter and result registers.

## Test plan

- Reset with random inputs held for 3 cycles → busy=done=y=z=gt=lt=eq=0; no done while rst=1.
- WIDTH=8, a=0xA5, b=0xA5, start pulse → busy high 8 cycles, done at T0+9, {y,z}=01, eq=1, gt=lt=0.
- a=0x80, b=0x7F → bit 7 differs, busy 1 cycle, done at T0+2, {y,z}=10, gt=1.
- a=0x12, b=0x13 → bit 0 differs, done at T0+9, {y,z}=11, lt=1. Result holds for 5 idle cycles, then clears to 0 on the next accepted start.
- During busy: hold start=1 and change a/b to 0xFF/0x00 → no restart, result reflects the latched operands. start held through DONE → accepted only on the following IDLE cycle.
- rst asserted at T0+3 of an equal-operand compare → no done pulse, outputs reset. A new start (a=0x01, b=0x00) then completes normally with gt=1 at T0'+9.
